// File: rtl/axi4_rd_credit_bridge.sv
// AXI4 read-path bridge: one-entry AR slice plus an R FIFO. A burst is only forwarded downstream
// once FIFO space is reserved for all of its beats, so the downstream R channel never backs up.
module axi4_rd_credit_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 6,
    parameter int RDEPTH  = 16,
    parameter int MAX_OUT = 4
) (
    input  logic                           ext_clk_in,
    input  logic                           FCLK_RESET0_N,
    input  logic                           S_AXI_arvalid,
    output logic                           S_AXI_arready,
    input  logic [ID_W-1:0]                S_AXI_arid,
    input  logic [ADDR_W-1:0]              S_AXI_araddr,
    input  logic [7:0]                     S_AXI_arlen,
    input  logic [20:0]                    S_AXI_arattr,
    output logic                           S_AXI_rvalid,
    input  logic                           S_AXI_rready,
    output logic [DATA_W-1:0]              S_AXI_rdata,
    output logic [ID_W+2:0]                S_AXI_rinfo,
    output logic                           M_AXI_arvalid,
    input  logic                           M_AXI_arready,
    output logic [ID_W-1:0]                M_AXI_arid,
    output logic [ADDR_W-1:0]              M_AXI_araddr,
    output logic [7:0]                     M_AXI_arlen,
    output logic [20:0]                    M_AXI_arattr,
    input  logic                           M_AXI_rvalid,
    output logic                           M_AXI_rready,
    input  logic [DATA_W-1:0]              M_AXI_rdata,
    input  logic [ID_W+2:0]                M_AXI_rinfo,
    output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt
);
    localparam int OW    = $clog2(MAX_OUT + 1);
    localparam int AW    = $clog2(RDEPTH);
    localparam int PW    = AW + 1;
    localparam int RSV_W = $clog2((RDEPTH > 256) ? RDEPTH : 256) + 1;
    localparam int NW    = RSV_W + 1;
    localparam int IW    = ID_W + 3;

    logic              r_up;
    logic              r_slot_full;
    logic [ID_W-1:0]   r_arid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic [20:0]       r_arattr;
    logic [RSV_W-1:0]  r_resv;
    logic [OW-1:0]     r_out;
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic              r_m_rready;
    logic [DATA_W-1:0] r_dmem [RDEPTH];
    logic [IW-1:0]     r_imem [RDEPTH];

    logic              w_s_ar_fire;
    logic              w_m_ar_fire;
    logic              w_push;
    logic              w_pop;
    logic              w_pop_last;
    logic              w_empty;
    logic              w_fits;
    logic [NW-1:0]     w_need;
    logic [PW-1:0]     w_cnt;
    logic [PW-1:0]     w_cnt_nxt;
    logic [RSV_W-1:0]  w_resv_add;
    logic [RSV_W-1:0]  w_resv_sub;

    // Oversized bursts (beats > RDEPTH) slip through only when nothing else holds a reservation.
    assign w_need = {{(NW-8){1'b0}}, r_arlen} + NW'(1) + {1'b0, r_resv};
    assign w_fits = (w_need <= NW'(RDEPTH)) || (r_resv == '0);

    assign M_AXI_arvalid = r_slot_full && (r_out < OW'(MAX_OUT)) && w_fits;
    assign w_m_ar_fire   = M_AXI_arvalid && M_AXI_arready;
    assign S_AXI_arready = r_up && (!r_slot_full || w_m_ar_fire);
    assign w_s_ar_fire   = S_AXI_arvalid && S_AXI_arready;

    assign M_AXI_arid   = r_arid;
    assign M_AXI_araddr = r_araddr;
    assign M_AXI_arlen  = r_arlen;
    assign M_AXI_arattr = r_arattr;

    assign w_empty      = (r_wp == r_rp);
    assign w_cnt        = r_wp - r_rp;
    assign w_cnt_nxt    = w_cnt + PW'(w_push) - PW'(w_pop);
    assign M_AXI_rready = r_m_rready;
    assign w_push       = M_AXI_rvalid && r_m_rready;
    assign S_AXI_rvalid = !w_empty;
    assign w_pop        = S_AXI_rvalid && S_AXI_rready;
    assign S_AXI_rdata  = w_empty ? '0 : r_dmem[r_rp[AW-1:0]];
    assign S_AXI_rinfo  = w_empty ? '0 : r_imem[r_rp[AW-1:0]];
    assign w_pop_last   = w_pop && S_AXI_rinfo[0];
    assign out_cnt      = r_out;

    assign w_resv_add = w_m_ar_fire ? (RSV_W'(r_arlen) + RSV_W'(1)) : '0;
    assign w_resv_sub = (w_pop && (r_resv != '0)) ? RSV_W'(1) : '0;

    always_ff @(posedge ext_clk_in or negedge FCLK_RESET0_N) begin
        if (!FCLK_RESET0_N) begin
            r_up        <= 1'b0;
            r_slot_full <= 1'b0;
            r_arid      <= '0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_arattr    <= '0;
            r_resv      <= '0;
            r_out       <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_m_rready  <= 1'b0;
        end else begin
            r_up <= 1'b1;
            if (w_s_ar_fire) begin
                r_slot_full <= 1'b1;
                r_arid      <= S_AXI_arid;
                r_araddr    <= S_AXI_araddr;
                r_arlen     <= S_AXI_arlen;
                r_arattr    <= S_AXI_arattr;
            end else if (w_m_ar_fire) begin
                r_slot_full <= 1'b0;
            end
            r_resv <= r_resv + w_resv_add - w_resv_sub;
            if (w_m_ar_fire && !w_pop_last)
                r_out <= r_out + OW'(1);
            else if (!w_m_ar_fire && w_pop_last)
                r_out <= r_out - OW'(1);
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            // Ready is computed from next-cycle occupancy so it never depends on S_AXI_rready combinationally.
            r_m_rready <= (w_cnt_nxt != PW'(RDEPTH));
        end
    end

    always_ff @(posedge ext_clk_in) begin
        if (w_push) begin
            r_dmem[r_wp[AW-1:0]] <= M_AXI_rdata;
            r_imem[r_wp[AW-1:0]] <= M_AXI_rinfo;
        end
    end

endmodule

// File: tb/tb_axi4_rd_credit_bridge.sv
// Randomised bench for axi4_rd_credit_bridge: queue-based reference model of the AR slot,
// reservation credits and R FIFO, with a negedge monitor acting as scoreboard.
module tb_axi4_rd_credit_bridge;
    localparam int ADDR_W = 32, DATA_W = 64, ID_W = 6, RDEPTH = 16, MAX_OUT = 4;
    localparam int OW = $clog2(MAX_OUT + 1);

    logic clk = 1'b0, rst_n = 1'b0;
    logic S_AXI_arvalid, S_AXI_arready, S_AXI_rvalid, S_AXI_rready;
    logic [ID_W-1:0] S_AXI_arid, M_AXI_arid;
    logic [ADDR_W-1:0] S_AXI_araddr, M_AXI_araddr;
    logic [7:0] S_AXI_arlen, M_AXI_arlen;
    logic [20:0] S_AXI_arattr, M_AXI_arattr;
    logic [DATA_W-1:0] S_AXI_rdata, M_AXI_rdata;
    logic [ID_W+2:0] S_AXI_rinfo, M_AXI_rinfo;
    logic M_AXI_arvalid, M_AXI_arready, M_AXI_rvalid, M_AXI_rready;
    logic [OW-1:0] out_cnt;

    always #5 clk = ~clk;

    axi4_rd_credit_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RDEPTH(RDEPTH),
                            .MAX_OUT(MAX_OUT)) dut (
        .ext_clk_in(clk), .FCLK_RESET0_N(rst_n),
        .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready), .S_AXI_arid(S_AXI_arid),
        .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen), .S_AXI_arattr(S_AXI_arattr),
        .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready), .S_AXI_rdata(S_AXI_rdata),
        .S_AXI_rinfo(S_AXI_rinfo),
        .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready), .M_AXI_arid(M_AXI_arid),
        .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen), .M_AXI_arattr(M_AXI_arattr),
        .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready), .M_AXI_rdata(M_AXI_rdata),
        .M_AXI_rinfo(M_AXI_rinfo), .out_cnt(out_cnt));

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [20:0]       attr;
    } ar_t;
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ID_W+2:0]   info;
    } rb_t;

    ar_t q_ar[$];    // accepted upstream, not yet forwarded
    ar_t q_iss[$];   // forwarded, downstream slave still owes beats
    rb_t q_r[$];     // beats inside the bridge, in delivery order
    int  m_out, m_resv, sl_beat;
    bit  m_up, r_fired;
    int  n_cmp, n_err;
    int  rr_mode, arr_mode, sv_prob;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Scoreboard/monitor: checks against the model state, then applies this cycle's handshakes.
    initial begin : mon
        bit ea, mf, sf, ps, pp;
        ar_t a;
        rb_t b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ea = (q_ar.size() > 0) && (m_out < MAX_OUT) &&
                     ((int'(q_ar[0].len) + 1 <= RDEPTH - m_resv) || (m_resv == 0));
                mf = M_AXI_arvalid && M_AXI_arready;
                chk("m_arvalid", M_AXI_arvalid, ea);
                chk("s_arready", S_AXI_arready, m_up && (q_ar.size() == 0 || mf));
                chk("m_rready", M_AXI_rready, m_up && (q_r.size() < RDEPTH));
                chk("s_rvalid", S_AXI_rvalid, q_r.size() > 0);
                chk("out_cnt", out_cnt, m_out);
                sf = S_AXI_arvalid && S_AXI_arready;
                ps = M_AXI_rvalid && M_AXI_rready;
                pp = S_AXI_rvalid && S_AXI_rready;
                if (pp) begin
                    if (q_r.size() == 0) timeout("r_unexpected");
                    else begin
                        b = q_r.pop_front();
                        chk("rdata", S_AXI_rdata, b.data);
                        chk("rinfo", S_AXI_rinfo, b.info);
                        m_resv--;
                        if (b.info[0]) m_out--;
                    end
                end
                if (mf) begin
                    if (q_ar.size() == 0) timeout("ar_unexpected");
                    else begin
                        a = q_ar.pop_front();
                        chk("m_ar_payload", {M_AXI_arid, M_AXI_araddr, M_AXI_arlen, M_AXI_arattr},
                            {a.id, a.addr, a.len, a.attr});
                        q_iss.push_back(a);
                        m_out++;
                        m_resv += int'(a.len) + 1;
                    end
                end
                if (sf) q_ar.push_back('{S_AXI_arid, S_AXI_araddr, S_AXI_arlen, S_AXI_arattr});
                if (ps) begin
                    q_r.push_back('{M_AXI_rdata, M_AXI_rinfo});
                    r_fired = 1;
                end
                m_up = 1;
            end
        end
    end

    // Downstream slave: returns beats for forwarded bursts in order, holding each until accepted.
    initial begin : slave
        M_AXI_rvalid = 0;
        M_AXI_rdata  = '0;
        M_AXI_rinfo  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (r_fired) begin
                r_fired = 0;
                M_AXI_rvalid = 0;
                if (M_AXI_rinfo[0]) begin
                    void'(q_iss.pop_front());
                    sl_beat = 0;
                end else sl_beat++;
            end
            if (rst_n && !M_AXI_rvalid && q_iss.size() > 0 && $urandom_range(0, 99) < sv_prob) begin
                M_AXI_rvalid = 1;
                M_AXI_rdata  = {$urandom, $urandom};
                M_AXI_rinfo  = {q_iss[0].id, 2'($urandom_range(0, 3)), sl_beat == int'(q_iss[0].len)};
            end
        end
    end

    initial begin : rr_drv
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0: S_AXI_rready = 0;
                1: S_AXI_rready = 1;
                2: S_AXI_rready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    initial begin : arr_drv
        forever begin
            @(posedge clk);
            #1;
            case (arr_mode)
                0: M_AXI_arready = 0;
                1: M_AXI_arready = 1;
                default: M_AXI_arready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] ad, input logic [7:0] ln);
        int n = 0;
        @(posedge clk);
        #1;
        S_AXI_arvalid = 1;
        S_AXI_arid    = id;
        S_AXI_araddr  = ad;
        S_AXI_arlen   = ln;
        S_AXI_arattr  = 21'($urandom);
        forever begin
            @(negedge clk);
            if (S_AXI_arready) break;
            if (++n > 3000) begin timeout("send_ar"); break; end
        end
        @(posedge clk);
        #1;
        S_AXI_arvalid = 0;
    endtask

    task automatic pop_n(input int n);
        int k = 0, t = 0;
        rr_mode = 3;
        @(posedge clk);
        #1;
        S_AXI_rready = 1;
        forever begin
            @(negedge clk);
            if (S_AXI_rvalid) k++;
            @(posedge clk);
            #1;
            if (k >= n) begin S_AXI_rready = 0; break; end
            if (++t > 500) begin timeout("pop_n"); S_AXI_rready = 0; break; end
        end
    endtask

    task automatic wait_fifo(input int n);
        int t = 0;
        while (q_r.size() < n) begin
            @(negedge clk);
            if (++t > 500) begin timeout("wait_fifo"); break; end
        end
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while (q_ar.size() > 0 || q_iss.size() > 0 || q_r.size() > 0 || m_out != 0) begin
            @(negedge clk);
            if (++t > 5000) begin timeout(nm); break; end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 0;
        q_ar.delete(); q_iss.delete(); q_r.delete();
        m_out = 0; m_resv = 0; m_up = 0; r_fired = 0; sl_beat = 0;
        M_AXI_rvalid = 0; S_AXI_arvalid = 0;
        #1;
        chk("rst_s_arready", S_AXI_arready, 0);
        chk("rst_s_rvalid", S_AXI_rvalid, 0);
        chk("rst_m_arvalid", M_AXI_arvalid, 0);
        chk("rst_m_rready", M_AXI_rready, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_data", {S_AXI_rdata, M_AXI_araddr}, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1;
    endtask

    initial begin
        S_AXI_arvalid = 0; S_AXI_arid = '0; S_AXI_araddr = '0; S_AXI_arlen = '0; S_AXI_arattr = '0;
        S_AXI_rready = 0; M_AXI_arready = 0;
        rr_mode = 1; arr_mode = 1; sv_prob = 100;
        do_reset();

        // single burst, timing of forward
        send_ar(6'd5, 32'h1000_0040, 8'd3);
        @(negedge clk);
        chk("t1_arvalid_next", M_AXI_arvalid, 1);
        wait_idle("t1_idle");
        chk("t1_out_end", out_cnt, 0);

        // reservation blocks third burst until two pops
        rr_mode = 0;
        send_ar(6'd1, 32'h100, 8'd7);
        send_ar(6'd2, 32'h200, 8'd7);
        send_ar(6'd3, 32'h300, 8'd1);
        wait_fifo(16);
        repeat (3) @(negedge clk);
        chk("t2_held", M_AXI_arvalid, 0);
        chk("t2_out", out_cnt, 2);
        pop_n(1);
        @(negedge clk);
        chk("t2_held1", M_AXI_arvalid, 0);
        pop_n(1);
        @(negedge clk);
        chk("t2_issue", M_AXI_arvalid, 1);
        rr_mode = 1;
        wait_idle("t2_idle");

        // outstanding-burst limit
        rr_mode = 0;
        for (int i = 0; i < 5; i++) send_ar(6'(10 + i), 32'(i * 64), 8'd0);
        wait_fifo(4);
        repeat (2) @(negedge clk);
        chk("t3_out4", out_cnt, 4);
        chk("t3_held", M_AXI_arvalid, 0);
        pop_n(1);
        @(negedge clk);
        chk("t3_issue", M_AXI_arvalid, 1);
        rr_mode = 1;
        wait_idle("t3_idle");

        // oversized burst plus full-FIFO pop/push interplay
        rr_mode = 0;
        send_ar(6'd20, 32'h2000, 8'd31);
        wait_fifo(16);
        repeat (3) @(negedge clk);
        chk("t4_full", M_AXI_rready, 0);
        rr_mode = 3;
        @(posedge clk);
        #1;
        S_AXI_rready = 1;
        @(negedge clk);
        chk("t5_pop_nopush", {S_AXI_rvalid, M_AXI_rready}, 2'b10);
        @(posedge clk);
        #1;
        S_AXI_rready = 0;
        @(negedge clk);
        chk("t5_push_next", M_AXI_rready, 1);
        rr_mode = 1;
        wait_idle("t4_idle");
        chk("t4_empty", S_AXI_rvalid, 0);

        // reset with beats buffered and an AR pending
        rr_mode = 0;
        send_ar(6'd30, 32'h3000, 8'd2);
        wait_fifo(3);
        send_ar(6'd31, 32'h3100, 8'd15);
        @(negedge clk);
        chk("t6_pending", M_AXI_arvalid, 0);
        do_reset();
        rr_mode = 1;
        send_ar(6'd32, 32'h3200, 8'd0);
        wait_idle("t6_idle");
        chk("t6_out_end", out_cnt, 0);

        // randomised traffic
        rr_mode = 2; arr_mode = 2; sv_prob = 70;
        for (int i = 0; i < 40; i++)
            send_ar(6'($urandom), $urandom,
                    ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 40)) : 8'($urandom_range(0, 12)));
        rr_mode = 1;
        wait_idle("rand_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
